// File: rtl/ps2_kbd_pkg.sv
// Shared constants, decoder state encoding and event packing for the PS/2 keyboard receiver.
// Pure definitions: no logic, no latency, no flow control.
package ps2_kbd_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam int EVT_W   = 10;
  localparam int EXT_BIT = 9;
  localparam int REL_BIT = 8;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  function automatic logic [EVT_W-1:0] mk_evt(input dec_state_t st, input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e          = '0;
    e[EXT_BIT] = (st == DEC_EXT) || (st == DEC_EXT_BRK);
    e[REL_BIT] = (st == DEC_BRK) || (st == DEC_EXT_BRK);
    e[7:0]     = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: sync, ps2clk glitch filter, start/parity/stop check, timeout watchdog.
// Latency: byte_valid / frame_err pulse one clk after the filtered falling edge (or timeout) that ends the frame.
// Backpressure: none; the keyboard cannot be stalled, so every byte is offered exactly once.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_flt;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;

  // The filtered level resets low, so the first accepted falling edge is always preceded by a settled high level.
  assign fall = clk_flt && !clk_sync[1] && (flt_cnt == FLT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b00;
      dat_sync <= 2'b11;
      clk_flt  <= 1'b0;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
      if (clk_sync[1] != clk_flt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_flt <= clk_sync[1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  // Parity is judged together with the stop bit so a bad frame yields one error and the stop edge is not mistaken for a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (dat_sync[1]) frame_err <= 1'b1;
          else             bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {dat_sync[1], shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_ok  <= ^{shreg, dat_sync[1]};
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= '0;
          if (dat_sync[1] && par_ok) begin
            rx_byte    <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          bit_cnt   <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_evt_fifo.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into {ext, rel, code} events and buffers them in a FWFT FIFO.
// Latency: evt_valid rises 2 clk after the filtered stop-bit edge into an empty FIFO; pop visible next cycle.
// Backpressure: evt_valid/evt_rd handshake; pushes into a full FIFO drop and set sticky overflow. Option: PS2_KBD_REPEAT_FILTER_EN.
module ps2_kbd_evt_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_rd,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          err_ind
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]       rx_byte;
  logic             byte_valid, frame_err;
  dec_state_t       state;
  logic [EVT_W-1:0] cand, push_evt;
  logic             is_emit, keep, push_vld;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign err_ind = frame_err;
  assign cand    = mk_evt(state, rx_byte);
  // E0 is never emitted; F0 is a prefix only before a break has been seen.
  assign is_emit = byte_valid && (rx_byte != PREFIX_EXT) &&
                   !((rx_byte == PREFIX_BRK) && ((state == DEC_IDLE) || (state == DEC_EXT)));

`ifdef PS2_KBD_REPEAT_FILTER_EN
  logic [8:0] rpt_key;
  logic       rpt_vld;

  assign keep = cand[REL_BIT] || !rpt_vld || (rpt_key != {cand[EXT_BIT], cand[7:0]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_key <= '0;
      rpt_vld <= 1'b0;
    end else if (is_emit) begin
      if (!cand[REL_BIT]) begin
        rpt_key <= {cand[EXT_BIT], cand[7:0]};
        rpt_vld <= 1'b1;
      end else if (rpt_key == {cand[EXT_BIT], cand[7:0]}) begin
        rpt_vld <= 1'b0;
      end
    end
  end
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DEC_IDLE;
      push_vld <= 1'b0;
      push_evt <= '0;
    end else begin
      push_vld <= 1'b0;
      if (frame_err) begin
        state <= DEC_IDLE;
      end else if (byte_valid) begin
        if (is_emit) begin
          state    <= DEC_IDLE;
          push_vld <= keep;
          push_evt <= cand;
        end else if (rx_byte == PREFIX_EXT) begin
          if (state == DEC_IDLE) state <= DEC_EXT;
        end else begin
          state <= (state == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
        end
      end
    end
  end

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_pop, do_wr, ovf_set;

  assign evt_valid = (evt_count != '0);
  assign full      = (evt_count == DEPTH_C);
  assign do_pop    = evt_rd && evt_valid;
  assign do_wr     = push_vld && (!full || do_pop);
  assign ovf_set   = push_vld && full && !do_pop;
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   evt_count <= evt_count + (AW + 1)'(1);
        2'b01:   evt_count <= evt_count - (AW + 1)'(1);
        default: evt_count <= evt_count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_evt_fifo.sv
// Self-checking bench for ps2_kbd_evt_fifo: bit-banged PS/2 frames in, scoreboard of expected events out.
// Honours PS2_KBD_REPEAT_FILTER_EN for the typematic-repeat scenario.
module tb_ps2_kbd_evt_fifo;

  localparam int DEPTH = 8;
  localparam int FLT   = 4;
  localparam int TO    = 300;

  logic       clk = 1'b0;
  logic       rst, ps2clk, ps2data, evt_rd, ovf_clr;
  logic [9:0] evt_data;
  logic       evt_valid, overflow, err_ind;
  logic [3:0] evt_count;

  logic [9:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int err_pulses = 0;
  int err_long = 0;
  logic err_prev = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_evt_fifo #(
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (FLT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .evt_data (evt_data),
    .evt_valid(evt_valid),
    .evt_rd   (evt_rd),
    .evt_count(evt_count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .err_ind  (err_ind)
  );

  always @(negedge clk) begin
    if (err_ind) begin
      err_pulses++;
      if (err_prev) err_long++;
    end
    err_prev = err_ind;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    repeat (10) @(negedge clk);
    ps2clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send_evt(input logic [7:0] b, input logic [9:0] exp_evt, input bit expect_it);
    send_frame(b, 1'b0, 11);
    if (expect_it) exp_q.push_back(exp_evt);
  endtask

  // Scoreboard consumer: pops each expected event against the FIFO head, then reads it out.
  task automatic consume(input string name);
    int waited;
    logic [9:0] exp_evt;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (!evt_valid && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      exp_evt = exp_q.pop_front();
      n_chk++;
      if (!evt_valid) begin
        n_fail++;
        $display("FAIL %s_timeout: no event, expected %h", name, exp_evt);
        exp_q.delete();
      end else begin
        if (evt_data !== exp_evt) begin
          n_fail++;
          $display("FAIL %s_data: got %h expected %h", name, evt_data, exp_evt);
        end
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; evt_rd = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (evt_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", evt_data); end
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_chk++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_chk++; if (err_ind !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_ind); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_make();
    send_evt(8'h1C, 10'h01C, 1);
    n_chk++; if (evt_count !== 4'd1) begin n_fail++; $display("FAIL make_count: got %0d expected 1", evt_count); end
    consume("make");
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL make_popped: valid %b expected 0", evt_valid); end
  endtask

  task automatic test_break_ext();
    send_evt(8'hF0, 10'h000, 0);
    send_evt(8'h1C, 10'h11C, 1);
    send_evt(8'hE0, 10'h000, 0);
    send_evt(8'hF0, 10'h000, 0);
    send_evt(8'h75, 10'h375, 1);
    n_chk++; if (evt_count !== 4'd2) begin n_fail++; $display("FAIL brk_ext_count: got %0d expected 2", evt_count); end
    consume("brk_ext");
  endtask

  task automatic test_parity_err();
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 11);
    n_chk++; if (err_pulses !== e0 + 1) begin n_fail++; $display("FAIL parity_err_pulses: got %0d expected %0d", err_pulses - e0, 1); end
    n_chk++; if (err_long !== 0) begin n_fail++; $display("FAIL parity_err_width: long pulses %0d expected 0", err_long); end
    n_chk++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL parity_no_evt: got %0d expected 0", evt_count); end
    send_evt(8'h1C, 10'h01C, 1);
    consume("parity_recover");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1'b0, 6);
    repeat (TO) @(negedge clk);
    n_chk++; if (err_pulses !== e0 + 1) begin n_fail++; $display("FAIL timeout_err: got %0d pulses expected 1", err_pulses - e0); end
    n_chk++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL timeout_no_evt: got %0d expected 0", evt_count); end
    send_evt(8'hF0, 10'h000, 0);
    send_evt(8'h1C, 10'h11C, 1);
    consume("timeout_recover");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH + 1; i++) send_evt(8'(i), 10'(i), i <= DEPTH);
    n_chk++; if (evt_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", evt_count); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_chk++; if (evt_data !== 10'h001) begin n_fail++; $display("FAIL ovf_head: got %h expected 001", evt_data); end
    consume("ovf_drain");
    n_chk++; if (evt_count !== 4'd0) begin n_fail++; $display("FAIL ovf_empty: got %0d expected 0", evt_count); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_repeat();
    bit filt;
`ifdef PS2_KBD_REPEAT_FILTER_EN
    filt = 1;
`else
    filt = 0;
`endif
    send_evt(8'h1C, 10'h01C, 1);
    send_evt(8'h1C, 10'h01C, !filt);
    send_evt(8'h1C, 10'h01C, !filt);
    send_evt(8'hF0, 10'h000, 0);
    send_evt(8'h1C, 10'h11C, 1);
    n_chk++; if (evt_count !== (filt ? 4'd2 : 4'd4)) begin n_fail++; $display("FAIL repeat_count: got %0d expected %0d", evt_count, filt ? 2 : 4); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL repeat_ovf: got %b expected 0", overflow); end
    consume("repeat");
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    send_frame(8'h1C, 1'b0, 11);
    n_chk++; if (evt_count !== 4'd1) begin n_fail++; $display("FAIL midrst_pre: got %0d expected 1", evt_count); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (evt_count !== 4'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: count %0d valid %b expected 0 0", evt_count, evt_valid); end
    ps2data = 1'b1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    e0 = err_pulses;
    send_evt(8'h1C, 10'h01C, 1);
    consume("midrst_resync");
    n_chk++; if (err_pulses !== e0) begin n_fail++; $display("FAIL midrst_err: got %0d pulses expected 0", err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break_ext();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_repeat();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_evt_fifo.md
# ps2_kbd_evt_fifo

Parametrised PS/2 keyboard receiver. It deserialises frames from the keyboard, folds the E0 (extended) and F0 (break) prefixes into a single key event, and buffers events in a FIFO with a valid/read handshake. It sits between the board PS/2 pins and the calendar/timer control logic. It replaces the single-byte, single-ack keyboard path with a generalised one that does not lose keys when the consumer is slow.

## Interface
Parameters:
- FIFO_DEPTH, 8: event buffer entries; power of two, ≥2
- FILTER_LEN, 4: consecutive equal samples needed to accept a ps2clk level change
- TIMEOUT_CYC, 50000: clk cycles allowed between ps2clk falling edges inside a frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ps2clk  in  1  raw PS/2 clock (asynchronous)
- ps2data  in  1  raw PS/2 data (asynchronous)
- evt_data  out  10  head event: {extended, released, scancode[7:0]}
- evt_valid  out  1  FIFO non-empty; evt_data is valid
- evt_rd  in  1  pops the head event when evt_valid=1
- evt_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow
- err_ind  out  1  one-cycle pulse on any frame error

## Operation
- ps2clk and ps2data each pass through a 2-FF synchroniser. ps2clk then passes through a FILTER_LEN glitch filter. A filtered 1→0 transition is a falling edge.
- Frame layout: start(0), 8 data bits LSB first, odd parity, stop(1). One bit is sampled per falling edge.
- Frame errors: start=1, parity wrong, stop=0, or timeout (more than TIMEOUT_CYC cycles with no edge in mid-frame). On any error:
  - err_ind pulses for one cycle.
  - The byte is discarded.
  - The deserialiser and the decoder both return to idle.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK.
  - From IDLE: E0→EXT, F0→BRK.
  - From EXT: F0→EXT_BRK.
  - Any other byte emits event {ext, rel, byte}, where ext=1 in EXT or EXT_BRK and rel=1 in BRK or EXT_BRK, then returns to IDLE.
  - E0 received in BRK, EXT or EXT_BRK: stay in the current state; the byte is ignored.
- FIFO is first-word-fall-through. evt_data shows the head entry. evt_data=0 when empty.
- evt_rd with evt_valid=0 is ignored.
- Push while full:
  - Without a pop in the same cycle: the event is dropped and overflow sets.
  - With a pop in the same cycle: both happen and count is unchanged.
- Push and pop on a non-full, non-empty FIFO: count is unchanged.
- ovf_clr and a new overflow in the same cycle: overflow stays 1 (set wins).
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: evt_data=0, evt_valid=0, evt_count=0, overflow=0, err_ind=0. Decoder state is IDLE, deserialiser is idle, FIFO is empty.
- Reset asserted mid-frame: the partial frame is lost. After reset release, the receiver resynchronises on the next start bit that follows at least one idle-high filtered ps2clk level.
- Latency: evt_valid rises 2 clk cycles after the filtered falling edge that samples the stop bit, when the FIFO was empty.
- err_ind pulses 1 cycle after the offending edge. For a timeout, it pulses 1 cycle after the TIMEOUT_CYC-th idle cycle.
- A pop takes effect on the evt_rd edge. The next entry appears on evt_data the following cycle.
- Maximum sustained rate: one event per 11 PS/2 bit times. Throughput is limited by ps2clk, not by clk.

## Configuration
- PS2_KBD_REPEAT_FILTER_EN
  - Defined: typematic repeats are suppressed. A make event whose {ext, scancode} equals the last emitted make is dropped until a break for that key, or a make of a different key, is emitted. Dropped repeats do not set overflow. Reset clears the remembered key.
  - Undefined: every make event is pushed, including repeats.

## Structure
- Package ps2_kbd_pkg holds:
  - PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0.
  - EVT_W=10 and the event field offsets (EXT_BIT=9, REL_BIT=8).
  - The decoder state encoding.
- Sub-module ps2_frame_rx contains synchronisers, glitch filter, bit counter, parity/stop check and timeout watchdog. It outputs byte[7:0], byte_valid (1-cycle pulse) and frame_err (1-cycle pulse).
- The top level holds the decoder FSM, the optional repeat filter and the FIFO.

## Test plan
- Send frame 0x1C → one event evt_data=10'h01C and evt_count=1. evt_rd → evt_valid=0 next cycle.
- Send F0,1C → event 10'h11C. Send E0,F0,75 → event 10'h375. Neither sequence produces events for the prefix bytes.
- Send 0x1C with the parity bit inverted → err_ind high for exactly 1 cycle and no event. Then send a good 0x1C → 10'h01C, confirming the decoder returned to IDLE.
- Abort after 5 data bits for more than TIMEOUT_CYC cycles → err_ind pulse and no event. A following F0,1C → 10'h11C.
- Push FIFO_DEPTH+1 events (0x01..0x09 with depth 8) and no reads:
  - evt_count=8, overflow=1, head=10'h001.
  - Drain yields 0x01..0x08.
  - ovf_clr → overflow=0.
- Send 1C,1C,1C,F0,1C:
  - Macro defined → events 10'h01C, 10'h11C.
  - Macro undefined → 10'h01C ×3, then 10'h11C.
